hazard_sequencer: RTL

//  Central pipeline-control sequencer: owns all stall/flush enables (incl. StallD/FlushD of the decode register).

---
 rtl/hazard_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
//   Central pipeline-control sequencer. It owns every stall/flush enable of the
//   pipeline and arbitrates between load-use, branch-mispredict, I-cache-miss
//   and D-cache-miss events. A three-state FSM (RUN/IMISS/DMISS) covers the
//   multi-cycle cache waits. A watchdog raises a sticky error when a miss wait
//   lasts MISS_TIMEOUT cycles. The stall/flush outputs are combinational from
//   the registered state and the current inputs, so they take effect in the
//   same cycle.
//
//   Parameters
//     MISS_TIMEOUT   cycles spent in IMISS/DMISS before TimeoutErr sets
//
//   Optional feature
//     HAZARD_PERF_CNT_EN  builds the StallCycles/FlushEvents counters. When it
//                         is undefined, both ports are tied to zero.
//
//   Ports
//     clk, reset_n            clock (rising edge), async active-low reset
//     LoadUseHazD             D-stage source matches E-stage load Rd
//     BranchMispredE          E-stage branch resolved against prediction
//     ICacheMissF/ReadyF      fetch miss (held) / fill done (pulse)
//     DCacheMissM/ReadyM      data miss (held) / fill done (pulse)
//     StallF/D/E/M            hold the matching pipeline register
//     FlushD/E/W              clear the matching pipeline register to a bubble
//     ICacheAbort             cancel an in-flight wrong-path I-fill (pulse)
//     TimeoutErr              sticky watchdog flag
//     StallCycles/FlushEvents 32-bit performance counters
// -----------------------------------------------------------------------------
module hazard_sequencer #(
    parameter int MISS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        LoadUseHazD,
    input  logic        BranchMispredE,
    input  logic        ICacheMissF,
    input  logic        ICacheReadyF,
    input  logic        DCacheMissM,
    input  logic        DCacheReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        ICacheAbort,
    output logic        TimeoutErr,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushEvents
);

    localparam int CW = $clog2(MISS_TIMEOUT + 1);
    localparam logic [CW-1:0] WMAX = CW'(MISS_TIMEOUT);

    typedef enum logic [1:0] {RUN, IMISS, DMISS} state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
        logic icache_abort;
    } ctl_t;

    state_t          state, state_nxt;
    ctl_t            ctl;
    logic [CW-1:0]   wcnt, wcnt_inc;
    logic            in_miss, entering;
    logic            timeout_q;

    // ---------------------------------------------------------------- FSM reg
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_nxt;
    end

    // ------------------------------------------ next state and control enables
    always_comb begin
        state_nxt = state;
        ctl       = '0;
        unique case (state)
            RUN: begin
                if (DCacheMissM)                          state_nxt = DMISS;
                else if (ICacheMissF && !BranchMispredE)  state_nxt = IMISS;

                if (BranchMispredE) begin
                    // The mispredict wins over a load-use stall: the
                    // dependent instruction is on the wrong path anyway.
                    ctl.flush_d = 1'b1;
                    ctl.flush_e = 1'b1;
                end else if (LoadUseHazD) begin
                    // Hold F/D and push a bubble into E. A concurrent I-miss
                    // must not flush D while D is held.
                    ctl.stall_f = 1'b1;
                    ctl.stall_d = 1'b1;
                    ctl.flush_e = 1'b1;
                end else if (ICacheMissF) begin
                    // D advances into E and a bubble enters D.
                    ctl.stall_f = 1'b1;
                    ctl.flush_d = 1'b1;
                end
            end

            IMISS: begin
                if (BranchMispredE)    state_nxt = RUN;
                else if (ICacheReadyF) state_nxt = RUN;
                else if (DCacheMissM)  state_nxt = DMISS;

                if (BranchMispredE) begin
                    // The pending fill is on the wrong path. Drop it and let
                    // F fetch the redirect target.
                    ctl.flush_d      = 1'b1;
                    ctl.flush_e      = 1'b1;
                    ctl.icache_abort = 1'b1;
                end else if (LoadUseHazD) begin
                    ctl.stall_f = 1'b1;
                    ctl.stall_d = 1'b1;
                    ctl.flush_e = 1'b1;
                end else begin
                    ctl.stall_f = 1'b1;
                    ctl.flush_d = 1'b1;
                end
            end

            DMISS: begin
                // Miss inputs are sampled again on the exit cycle. An I-miss
                // that is still pending is serviced next.
                if (DCacheReadyM) state_nxt = ICacheMissF ? IMISS : RUN;

                // The whole front of the pipe freezes and W takes bubbles.
                // A mispredict in E is held with E and shows up again after
                // the exit.
                ctl.stall_f = 1'b1;
                ctl.stall_d = 1'b1;
                ctl.stall_e = 1'b1;
                ctl.stall_m = 1'b1;
                ctl.flush_w = 1'b1;
            end

            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign StallF      = ctl.stall_f;
    assign StallD      = ctl.stall_d;
    assign StallE      = ctl.stall_e;
    assign StallM      = ctl.stall_m;
    assign FlushD      = ctl.flush_d;
    assign FlushE      = ctl.flush_e;
    assign FlushW      = ctl.flush_w;
    assign ICacheAbort = ctl.icache_abort;

    // --------------------------------------------------------------- watchdog
    // The counter restarts on every entry into a miss state, including a
    // DMISS->IMISS hand-off. It saturates at MISS_TIMEOUT, so it never wraps
    // back below the threshold.
    assign in_miss  = (state != RUN);
    assign entering = (state_nxt != RUN) && (state_nxt != state);
    assign wcnt_inc = (wcnt == WMAX) ? wcnt : wcnt + CW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (entering)     wcnt <= '0;
            else if (in_miss) wcnt <= wcnt_inc;

            if (in_miss && (wcnt_inc == WMAX)) timeout_q <= 1'b1;
        end
    end

    assign TimeoutErr = timeout_q;

    // ----------------------------------------------------- performance counters
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, flush_events_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (ctl.stall_d)                    stall_cycles_q <= stall_cycles_q + 32'd1;
            if (ctl.flush_e && BranchMispredE)  flush_events_q <= flush_events_q + 32'd1;
        end
    end

    assign StallCycles = stall_cycles_q;
    assign FlushEvents = flush_events_q;
`else
    assign StallCycles = '0;
    assign FlushEvents = '0;
`endif

endmodule
